// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_DIV    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam logic [15:0] DIV_RESET_DEFAULT = 16'd868;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with full/empty flags and an occupancy count.
module uart_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [Width-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Flags are sampled before this cycle's pop, so a push into a full FIFO is lost.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// CPU-programmable UART transmitter: register file, TX FIFO and 8N1 framing FSM.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = DIV_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_s_out,
    output logic        tx_busy
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]      fifo_head;
    logic [CntW-1:0] fifo_count;
    logic [3:0]      count4;
    logic            wr_data;

    tx_state_e   state_q, state_d;
    logic [15:0] div_reg_q, div_reg_d;
    logic [15:0] div_act_q, div_act_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        line_q, line_d;
    logic        ovf_q, ovf_d;
    logic        baud_done;

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:16];

    uart_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (fifo_push),
        .wdata_i (wdata[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign wr_data   = wr_en && (addr == ADDR_DATA);
    assign fifo_push = wr_data && !fifo_full;
    assign tx_busy   = (state_q != StIdle) || !fifo_empty;
    assign count4    = 4'(fifo_count);
    assign baud_done = (baud_cnt_q == 16'd0);

    always_comb begin
        div_reg_d = div_reg_q;
        ovf_d     = ovf_q;
        if (wr_en && (addr == ADDR_DIV)) begin
            div_reg_d = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
        end
        if (wr_data && fifo_full) begin
            ovf_d = 1'b1;
        end else if (wr_en && (addr == ADDR_STATUS) && wdata[2]) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_act_d  = div_act_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        line_d     = line_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            StIdle: begin
                line_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_head;
                    div_act_d  = div_reg_q;
                    baud_cnt_d = div_reg_q - 16'd1;
                    line_d     = 1'b0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (baud_done) begin
                    line_d     = shift_q[0];
                    shift_d    = shift_q >> 1;
                    bit_idx_d  = 3'd0;
                    baud_cnt_d = div_act_q - 16'd1;
                    state_d    = StData;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_cnt_d = div_act_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        line_d  = 1'b1;
                        state_d = StStop;
                    end else begin
                        line_d    = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (baud_done) begin
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_d    = fifo_head;
                        div_act_d  = div_reg_q;
                        baud_cnt_d = div_reg_q - 16'd1;
                        line_d     = 1'b0;
                        state_d    = StStart;
                    end else begin
                        line_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: begin
                line_d  = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            div_reg_q  <= DIV_RESET;
            div_act_q  <= DIV_RESET;
            baud_cnt_q <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            line_q     <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_reg_q  <= div_reg_d;
            div_act_q  <= div_act_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            line_q     <= line_d;
            ovf_q      <= ovf_d;
        end
    end

    assign uart_s_out = line_q;

    always_comb begin
        rdata = 32'd0;
        if (rd_en) begin
            case (addr)
                ADDR_DIV:    rdata = {16'd0, div_reg_q};
                ADDR_STATUS: rdata = {20'd0, count4, 4'd0, fifo_empty, ovf_q, fifo_full, tx_busy};
                default:     rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: register vector table plus framing corner-case sequences.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam logic [15:0] DivRst = 16'd868;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        uart_s_out;
    logic        tx_busy;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_ctrl #(
        .FIFO_DEPTH (8),
        .DIV_RESET  (DivRst)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .uart_s_out (uart_s_out),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
        logic        exp_busy;
        logic        exp_line;
    } vec_t;

    vec_t vecs[11];

    logic [7:0] fr_byte[$];
    int         fr_div[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wr_en = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;
    endtask

    task automatic reg_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        rd_en = 1'b1;
        addr  = a;
        #1;
        check(name, rdata, exp);
        rd_en = 1'b0;
        addr  = 2'd0;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Starts together with the first DATA write; skips the push edge and the START edge.
    task automatic expect_frames(input string name);
        @(posedge clk);
        @(posedge clk);
        for (int f = 0; f < fr_byte.size(); f++) begin
            for (int i = 0; i < 10 * fr_div[f]; i++) begin
                @(negedge clk);
                check1($sformatf("%s_f%0d_s%0d", name, f, i), uart_s_out,
                       frame_bit(fr_byte[f], i / fr_div[f]));
            end
        end
        @(negedge clk);
        check1({name, "_idle_line"}, uart_s_out, 1'b1);
        check1({name, "_idle_busy"}, tx_busy, 1'b0);
        fr_byte.delete();
        fr_div.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int hi_cnt;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;

        //                 wr    rd    addr         wdata         rdata        busy  line
        vecs[0]  = '{1'b0, 1'b1, ADDR_STATUS, 32'h0,       32'h0000_0008, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, ADDR_DIV,    32'h0,       32'h0000_0364, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, ADDR_DATA,   32'h0,       32'h0,         1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 2'd3,        32'h0,       32'h0,         1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, ADDR_DIV,    32'h0,       32'h0,         1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, ADDR_DIV,    32'h0,       32'h0000_0001, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, ADDR_DIV,    32'hABCD_0004, 32'h0,       1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, ADDR_DIV,    32'h0,       32'h0000_0004, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 2'd3,        32'h0000_FFFF, 32'h0,       1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, ADDR_DIV,    32'h0,       32'h0000_0004, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, ADDR_STATUS, 32'h0,       32'h0,         1'b0, 1'b1};

        repeat (3) tick();
        check1("reset_line", uart_s_out, 1'b1);
        check1("reset_busy", tx_busy, 1'b0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            wr_en = vecs[i].wr;
            rd_en = vecs[i].rd;
            addr  = vecs[i].a;
            wdata = vecs[i].d;
            @(negedge clk);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check1($sformatf("vec%0d_busy", i), tx_busy, vecs[i].exp_busy);
            check1($sformatf("vec%0d_line", i), uart_s_out, vecs[i].exp_line);
            tick();
            wr_en = 1'b0;
            rd_en = 1'b0;
            addr  = 2'd0;
            wdata = 32'd0;
        end

        // Single frame at DIV=4 (divisor already 4 from the table).
        fr_byte.push_back(8'hA5);
        fr_div.push_back(4);
        fork
            reg_wr(ADDR_DATA, 32'h0000_00A5);
            expect_frames("a5");
        join

        // Three back-to-back frames at DIV=2.
        reg_wr(ADDR_DIV, 32'd2);
        fr_byte.push_back(8'h01); fr_div.push_back(2);
        fr_byte.push_back(8'h02); fr_div.push_back(2);
        fr_byte.push_back(8'h03); fr_div.push_back(2);
        fork
            begin
                reg_wr(ADDR_DATA, 32'h01);
                reg_wr(ADDR_DATA, 32'h02);
                reg_wr(ADDR_DATA, 32'h03);
            end
            expect_frames("b2b");
        join

        // Divisor change mid-frame only affects the next frame.
        reg_wr(ADDR_DIV, 32'd4);
        fr_byte.push_back(8'h3C); fr_div.push_back(4);
        fr_byte.push_back(8'hC3); fr_div.push_back(8);
        fork
            begin
                reg_wr(ADDR_DATA, 32'h3C);
                repeat (10) tick();
                reg_wr(ADDR_DIV, 32'd8);
                reg_wr(ADDR_DATA, 32'hC3);
            end
            expect_frames("divchg");
        join
        reg_wr(ADDR_DIV, 32'd0);
        reg_rd("div_zero_reads_one", ADDR_DIV, 32'd1);
        tick();

        // Fill the FIFO behind a slow frame, then overflow and clear.
        reg_wr(ADDR_DIV, 32'd100);
        for (int i = 0; i < 9; i++) begin
            reg_wr(ADDR_DATA, 32'h10 + i);
        end
        reg_rd("fill_status", ADDR_STATUS, 32'h0000_0803);
        check1("fill_line_start", uart_s_out, 1'b0);
        tick();
        reg_wr(ADDR_DATA, 32'hEE);
        reg_rd("ovf_status", ADDR_STATUS, 32'h0000_0807);
        tick();
        reg_wr(ADDR_STATUS, 32'h4);
        reg_rd("ovf_clear_status", ADDR_STATUS, 32'h0000_0803);
        tick();
        rst = 1'b0;
        #1;
        check1("flush_rst_line", uart_s_out, 1'b1);
        tick();
        rst = 1'b1;
        reg_rd("flush_status", ADDR_STATUS, 32'h0000_0008);
        tick();

        // Reset during data bit 3 of 0xA5 at DIV=4.
        reg_wr(ADDR_DIV, 32'd4);
        reg_wr(ADDR_DATA, 32'hA5);
        repeat (19) @(negedge clk);
        check1("pre_rst_line_bit3", uart_s_out, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check1("rst_line_immediate", uart_s_out, 1'b1);
        check1("rst_busy", tx_busy, 1'b0);
        reg_rd("rst_status_during", ADDR_STATUS, 32'h0000_0008);
        tick();
        rst = 1'b1;
        reg_rd("rst_status_after", ADDR_STATUS, 32'h0000_0008);
        reg_rd("rst_div_after", ADDR_DIV, {16'd0, DivRst});
        hi_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_s_out === 1'b1 && tx_busy === 1'b0) hi_cnt++;
        end
        check("rst_no_retransmit_cycles", hi_cnt, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
